// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bundle widths, bit positions and ALUOp encodings.
// Used by the ID/EX register, its hazard detector and later the forwarding unit.
package pipeline_pkg;

  localparam int WB_W  = 2;
  localparam int MEM_W = 2;
  localparam int EX_W  = 4;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int MEM_WRITE   = 1;
  localparam int MEM_READ    = 0;
  localparam int EX_ALUSRC   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_REGDST   = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic [WB_W-1:0]  wb;
    logic [MEM_W-1:0] mem;
    logic [EX_W-1:0]  ex;
  } ctrl_t;

  function automatic logic is_load(input logic [MEM_W-1:0] mem);
    return mem[MEM_READ];
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register; slave = the stage, master = its environment.
interface id_ex_stage_if
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              id_valid_i;
  logic [WB_W-1:0]   id_wb_i;
  logic [MEM_W-1:0]  id_mem_i;
  logic [EX_W-1:0]   id_ex_i;
  logic [DATA_W-1:0] id_rs_data_i;
  logic [DATA_W-1:0] id_rt_data_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic [REG_AW-1:0] id_rd_i;

  logic              stall_o;
  logic              ex_valid_o;
  logic [WB_W-1:0]   ex_wb_o;
  logic [MEM_W-1:0]  ex_mem_o;
  logic [EX_W-1:0]   ex_ex_o;
  logic [DATA_W-1:0] ex_rs_data_o;
  logic [DATA_W-1:0] ex_rt_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [REG_AW-1:0] ex_rs_o;
  logic [REG_AW-1:0] ex_rt_o;
  logic [REG_AW-1:0] ex_rd_o;

  modport slave (
    input  id_valid_i, id_wb_i, id_mem_i, id_ex_i, id_rs_data_i, id_rt_data_i, id_imm_i,
           id_rs_i, id_rt_i, id_rd_i,
    output stall_o, ex_valid_o, ex_wb_o, ex_mem_o, ex_ex_o, ex_rs_data_o, ex_rt_data_o,
           ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o
  );

  modport master (
    output id_valid_i, id_wb_i, id_mem_i, id_ex_i, id_rs_data_i, id_rt_data_i, id_imm_i,
           id_rs_i, id_rt_i, id_rd_i,
    input  stall_o, ex_valid_o, ex_wb_o, ex_mem_o, ex_ex_o, ex_rs_data_o, ex_rt_data_o,
           ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o
  );
endinterface

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: pure combinational, zero latency; stalls when EX holds a load whose rt feeds ID.
module load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_rt_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  output logic              stall_o
);
  // rt is compared even for I-type consumers; the occasional needless stall is harmless.
  assign stall_o = ex_valid_i & ex_mem_read_i & (ex_rt_i != '0) & id_valid_i &
                   ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register, 1-cycle latency; priority hold > flush > load-use stall > load, bubbles on flush/stall.
// ID_EX_PERF_EN adds saturating bubble/flush counters; stall_o freezes PC and IF/ID upstream.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
`ifdef ID_EX_PERF_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              hold_i,
  input  logic              flush_i,
  id_ex_stage_if.slave      bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  ctrl_t             ctrl_q, ctrl_d, id_ctrl;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d;
  logic [REG_AW-1:0] rt_q, rt_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic              stall;

  assign id_ctrl = {bus.id_wb_i, bus.id_mem_i, bus.id_ex_i};

  load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (is_load(ctrl_q.mem)),
    .ex_rt_i       (rt_q),
    .id_valid_i    (bus.id_valid_i),
    .id_rs_i       (bus.id_rs_i),
    .id_rt_i       (bus.id_rt_i),
    .stall_o       (stall)
  );

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    if (!hold_i) begin
      rs_data_d = bus.id_rs_data_i;
      rt_data_d = bus.id_rt_data_i;
      imm_d     = bus.id_imm_i;
      rs_d      = bus.id_rs_i;
      rt_d      = bus.id_rt_i;
      rd_d      = bus.id_rd_i;
      // A bubble only needs its control cleared; the operand fields are don't-care.
      if (flush_i || stall) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else begin
        valid_d = bus.id_valid_i;
        ctrl_d  = bus.id_valid_i ? id_ctrl : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
    end
  end

  assign bus.stall_o      = stall;
  assign bus.ex_valid_o   = valid_q;
  assign bus.ex_wb_o      = ctrl_q.wb;
  assign bus.ex_mem_o     = ctrl_q.mem;
  assign bus.ex_ex_o      = ctrl_q.ex;
  assign bus.ex_rs_data_o = rs_data_q;
  assign bus.ex_rt_data_o = rt_data_q;
  assign bus.ex_imm_o     = imm_q;
  assign bus.ex_rs_o      = rs_q;
  assign bus.ex_rt_o      = rt_q;
  assign bus.ex_rd_o      = rd_q;

`ifdef ID_EX_PERF_EN
  logic [CNT_W-1:0] bubble_cnt_q, flush_cnt_q;

  // A flush coinciding with a load-use stall is counted as a flush only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else if (!hold_i) begin
      if (flush_i) begin
        if (!(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end else if (stall) begin
        if (!(&bubble_cnt_q)) bubble_cnt_q <= bubble_cnt_q + 1'b1;
      end
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for single-cycle behaviour, hand sequences for reset and saturation.
module tb_id_ex_stage;
  import pipeline_pkg::*;

  localparam logic [3:0] EX_I = {1'b1, ALUOP_ADD, 1'b0};
  localparam logic [3:0] EX_R = {1'b0, ALUOP_RTYPE, 1'b1};

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic hold_i;
  logic flush_i;
  int   n_checks = 0;
  int   n_errors = 0;

  id_ex_stage_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef ID_EX_PERF_EN
  logic [3:0] bubble_cnt_o, flush_cnt_o;
  id_ex_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .hold_i(hold_i), .flush_i(flush_i), .bus(bus),
    .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o));
`else
  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .hold_i(hold_i), .flush_i(flush_i), .bus(bus));
`endif

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic hold, flush, valid;
    logic [1:0] wb, mem;
    logic [3:0] ex;
    logic [31:0] imm;
    logic [4:0] rs, rt, rd;
    logic e_stall, e_valid;
    logic [1:0] e_wb, e_mem;
    logic [3:0] e_ex;
    int e_src, e_bcnt, e_fcnt;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic hold, input logic flush, input logic valid, input logic [1:0] wb,
                       input logic [1:0] mem, input logic [3:0] ex, input logic [31:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input int tag);
    hold_i = hold;
    flush_i = flush;
    bus.id_valid_i = valid;
    bus.id_wb_i = wb;
    bus.id_mem_i = mem;
    bus.id_ex_i = ex;
    bus.id_imm_i = imm;
    bus.id_rs_i = rs;
    bus.id_rt_i = rt;
    bus.id_rd_i = rd;
    bus.id_rs_data_i = 32'hA000_0000 + tag;
    bus.id_rt_data_i = 32'hB000_0000 + tag;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".stall"}, bus.stall_o, 0);
    chk({tag, ".valid"}, bus.ex_valid_o, 0);
    chk({tag, ".ctrl"}, {bus.ex_wb_o, bus.ex_mem_o, bus.ex_ex_o}, 0);
    chk({tag, ".data"}, {bus.ex_rs_data_o, bus.ex_rt_data_o}, 0);
    chk({tag, ".imm"}, bus.ex_imm_o, 0);
    chk({tag, ".regs"}, {bus.ex_rs_o, bus.ex_rt_o, bus.ex_rd_o}, 0);
`ifdef ID_EX_PERF_EN
    chk({tag, ".cnt"}, {bubble_cnt_o, flush_cnt_o}, 0);
`endif
  endtask

  initial begin
    //           hold flush vld  wb     mem    ex    imm       rs  rt  rd | stall vld wb     mem    ex    src b f
    vec[0]  = '{0, 0, 1, 2'b10, 2'b00, EX_I, 32'd5,    1,  2,  0,   0, 1, 2'b10, 2'b00, EX_I, 0,  0, 0};
    vec[1]  = '{0, 0, 1, 2'b11, 2'b01, EX_I, 32'd0,    1,  3,  0,   0, 1, 2'b11, 2'b01, EX_I, 1,  0, 0};
    vec[2]  = '{0, 0, 1, 2'b10, 2'b00, EX_R, 32'h2020, 3,  5,  4,   1, 0, 2'b00, 2'b00, 4'h0, 2,  1, 0};
    vec[3]  = '{0, 0, 1, 2'b10, 2'b00, EX_R, 32'h2020, 3,  5,  4,   0, 1, 2'b10, 2'b00, EX_R, 3,  1, 0};
    vec[4]  = '{0, 0, 1, 2'b11, 2'b01, EX_I, 32'd4,    1,  0,  0,   0, 1, 2'b11, 2'b01, EX_I, 4,  1, 0};
    vec[5]  = '{0, 0, 1, 2'b10, 2'b00, EX_R, 32'h2020, 0,  5,  4,   0, 1, 2'b10, 2'b00, EX_R, 5,  1, 0};
    vec[6]  = '{0, 0, 0, 2'b11, 2'b11, 4'hF, 32'd9,    7,  7,  7,   0, 0, 2'b00, 2'b00, 4'h0, 6,  1, 0};
    vec[7]  = '{0, 0, 1, 2'b11, 2'b01, EX_I, 32'd8,    2,  6,  0,   0, 1, 2'b11, 2'b01, EX_I, 7,  1, 0};
    vec[8]  = '{0, 1, 1, 2'b00, 2'b10, EX_I, 32'd12,   1,  6,  0,   1, 0, 2'b00, 2'b00, 4'h0, 8,  1, 1};
    vec[9]  = '{0, 0, 1, 2'b11, 2'b01, EX_I, 32'd16,   1,  8,  0,   0, 1, 2'b11, 2'b01, EX_I, 9,  1, 1};
    vec[10] = '{1, 1, 1, 2'b10, 2'b00, EX_R, 32'h2020, 8,  8,  4,   1, 1, 2'b11, 2'b01, EX_I, 9,  1, 1};
    vec[11] = '{1, 1, 1, 2'b10, 2'b00, EX_R, 32'd99,   9,  10, 4,   0, 1, 2'b11, 2'b01, EX_I, 9,  1, 1};
    vec[12] = '{1, 0, 0, 2'b11, 2'b01, EX_I, 32'd3,    8,  8,  0,   0, 1, 2'b11, 2'b01, EX_I, 9,  1, 1};
    vec[13] = '{0, 0, 1, 2'b10, 2'b00, EX_R, 32'h2020, 9,  10, 4,   0, 1, 2'b10, 2'b00, EX_R, 13, 1, 1};
    vec[14] = '{0, 0, 1, 2'b11, 2'b01, EX_I, 32'd0,    10, 11, 0,   0, 1, 2'b11, 2'b01, EX_I, 14, 1, 1};
    vec[15] = '{0, 0, 1, 2'b11, 2'b01, EX_I, 32'd0,    11, 12, 0,   1, 0, 2'b00, 2'b00, 4'h0, 15, 2, 1};
    vec[16] = '{0, 0, 1, 2'b11, 2'b01, EX_I, 32'd0,    11, 12, 0,   0, 1, 2'b11, 2'b01, EX_I, 16, 2, 1};
    vec[17] = '{0, 0, 1, 2'b10, 2'b00, EX_R, 32'h2020, 13, 12, 4,   1, 0, 2'b00, 2'b00, 4'h0, 17, 3, 1};

    rst_n_i = 1'b0;
    drive(0, 0, 1, 2'b11, 2'b01, EX_I, 32'h55, 3, 3, 3, 77);
    #2;
    chk_all_zero("reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vec[i].hold, vec[i].flush, vec[i].valid, vec[i].wb, vec[i].mem, vec[i].ex,
            vec[i].imm, vec[i].rs, vec[i].rt, vec[i].rd, i);
      #1;
      chk($sformatf("v%0d.stall", i), bus.stall_o, vec[i].e_stall);
      @(posedge clk_i);
      #1;
      chk($sformatf("v%0d.valid", i), bus.ex_valid_o, vec[i].e_valid);
      chk($sformatf("v%0d.ctrl", i), {bus.ex_wb_o, bus.ex_mem_o, bus.ex_ex_o},
          {vec[i].e_wb, vec[i].e_mem, vec[i].e_ex});
      chk($sformatf("v%0d.imm", i), bus.ex_imm_o, vec[vec[i].e_src].imm);
      chk($sformatf("v%0d.regs", i), {bus.ex_rs_o, bus.ex_rt_o, bus.ex_rd_o},
          {vec[vec[i].e_src].rs, vec[vec[i].e_src].rt, vec[vec[i].e_src].rd});
      chk($sformatf("v%0d.data", i), {bus.ex_rs_data_o, bus.ex_rt_data_o},
          {32'hA000_0000 + vec[i].e_src, 32'hB000_0000 + vec[i].e_src});
`ifdef ID_EX_PERF_EN
      chk($sformatf("v%0d.bcnt", i), bubble_cnt_o, vec[i].e_bcnt);
      chk($sformatf("v%0d.fcnt", i), flush_cnt_o, vec[i].e_fcnt);
`endif
      @(negedge clk_i);
    end

`ifdef ID_EX_PERF_EN
    // 14 more load-use bubbles on top of 3 drive the 4-bit counter past its limit.
    for (int k = 0; k < 14; k++) begin
      drive(0, 0, 1, 2'b11, 2'b01, EX_I, 32'd0, 1, 13, 0, 100 + k);
      @(negedge clk_i);
      drive(0, 0, 1, 2'b10, 2'b00, EX_R, 32'h2020, 13, 5, 4, 200 + k);
      @(negedge clk_i);
    end
    chk("sat.bcnt", bubble_cnt_o, 4'hF);
    chk("sat.fcnt", flush_cnt_o, 4'h1);
`endif

    // Set up a live hazard, then reset mid-cycle with no clock edge.
    drive(0, 0, 1, 2'b11, 2'b01, EX_I, 32'd0, 1, 20, 0, 300);
    @(negedge clk_i);
    drive(0, 0, 1, 2'b10, 2'b00, EX_R, 32'h2020, 20, 5, 4, 301);
    #1;
    chk("pre_rst.stall", bus.stall_o, 1);
    chk("pre_rst.mem", bus.ex_mem_o, 2'b01);
    #1;
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("post_rst.valid", bus.ex_valid_o, 1);
    chk("post_rst.ex", bus.ex_ex_o, EX_R);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
